// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants and types for the VGA sync generator
// and the game logic that draws into its coordinate space.
package vga_sync_gen_pkg;

  // Default 640x480@60 horizontal timing, in pixels
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Default 640x480@60 vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // System clocks per pixel for the default build
  localparam int VGA_CLK_DIV  = 2;

  // Counter width; every axis total has to fit in it
  localparam int VGA_CNT_W     = 10;
  localparam int VGA_MAX_TOTAL = 1 << VGA_CNT_W;

  // Playfield size seen by the game logic
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

  // Screen coordinate used by the game logic
  typedef struct packed {
    logic [VGA_CNT_W-1:0] x;
    logic [VGA_CNT_W-1:0] y;
  } pt2D;

  // Full period of one axis
  function automatic int vga_total(input int active, input int fp,
                                   input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus the active-region and
// sync flags decoded from the position it is about to take, so the flags
// line up with the count in every cycle.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int   TOTAL  = 800,
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter logic POL    = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  output vga_cnt_t cnt,
  output logic     wrap,
  output logic     active,
  output logic     sync_o
);

  localparam vga_cnt_t LAST    = vga_cnt_t'(TOTAL - 1);
  localparam int       SYNC_LO = ACTIVE + FP;
  localparam int       SYNC_HI = ACTIVE + FP + SYNC;

  // Window test done in int so a window ending at the full counter range
  // cannot alias to zero.
  function automatic logic in_window(input vga_cnt_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

  vga_cnt_t cnt_q, cnt_d;
  logic     active_q;
  logic     sync_q;

  // Next position: wrap to zero after the last one
  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + vga_cnt_t'(1);
  end

  // Advance on enable; flags decoded from the new position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= LAST;
      active_q <= 1'b0;
      sync_q   <= ~POL;
    end else if (en) begin
      cnt_q    <= cnt_d;
      active_q <= in_window(cnt_d, 0, ACTIVE);
      sync_q   <= in_window(cnt_d, SYNC_LO, SYNC_HI) ? POL : ~POL;
    end
  end

  assign cnt    = cnt_q;
  assign active = active_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: divides the system clock down to the pixel rate
// and drives the pixel column/line counters, syncs, active-video flag and
// line/frame strobes consumed by the draw comparators.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter int   CLK_DIV  = VGA_CLK_DIV,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] ppc,
  output logic [9:0] plc,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 1 : 0);

  generate
    if ((H_TOTAL > VGA_MAX_TOTAL) || (V_TOTAL > VGA_MAX_TOTAL) || (CLK_DIV < 1)) begin : g_bad_cfg
      $error("vga_sync_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick_q;
  logic             line_start_q;
  logic             frame_start_q;

  vga_cnt_t h_cnt, v_cnt;
  logic     h_wrap, v_wrap;
  logic     h_active, v_active;
  logic     h_sync, v_sync;
  logic     v_en;

  // Pixel-rate divider position
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  // Line advances on the pixel tick that wraps the column counter
  assign v_en = pix_tick_q & h_wrap;

  // Divider, pixel tick and strobes; strobes are raised only on the edge
  // that moves the counters to column 0, so they last one system clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= (div_d == DIV_LAST);
      line_start_q  <= pix_tick_q & h_wrap;
      frame_start_q <= pix_tick_q & h_wrap & v_wrap;
    end
  end

  vga_axis_counter #(
    .TOTAL  (H_TOTAL),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .POL    (SYNC_POL)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pix_tick_q),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync_o (h_sync)
  );

  vga_axis_counter #(
    .TOTAL  (V_TOTAL),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .POL    (SYNC_POL)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (v_en),
    .cnt    (v_cnt),
    .wrap   (v_wrap),
    .active (v_active),
    .sync_o (v_sync)
  );

  assign pix_tick    = pix_tick_q;
  assign ppc         = h_cnt;
  assign plc         = v_cnt;
  assign hsync       = h_sync;
  assign vsync       = v_sync;
  assign video_on    = h_active & v_active;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing at CLK_DIV=2, the same
// timing at CLK_DIV=1, and a tiny 15x8 raster (CLK_DIV=3, active-high
// sync) small enough to walk a whole frame.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Default timing, CLK_DIV=2
  logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_ppc, a_plc;
  // Default timing, CLK_DIV=1
  logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_ppc, b_plc;
  // Small raster: H 8/2/3/2 (15), V 4/1/2/1 (8), CLK_DIV=3, SYNC_POL=1
  logic       c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_ppc, c_plc;

  vga_sync_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_tick(a_tick), .ppc(a_ppc), .plc(a_plc),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .pix_tick(b_tick), .ppc(b_ppc), .plc(b_plc),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_tick(c_tick), .ppc(c_ppc), .plc(c_plc),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .line_start(c_ls), .frame_start(c_fs)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ecnt  = 0;   // rising edges since the last reset release

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge after rising edge e (counted from release)
  task automatic step_to(input int e);
    while (ecnt < e) begin
      @(negedge clk);
      ecnt++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  // Reset values of the default-timing instance
  task automatic chk_reset_dflt(input string pfx);
    chk({pfx, " ppc"},  32'(a_ppc), 799);
    chk({pfx, " plc"},  32'(a_plc), 524);
    chk({pfx, " hs"},   32'(a_hs),  1);
    chk({pfx, " vs"},   32'(a_vs),  1);
    chk({pfx, " von"},  32'(a_von), 0);
    chk({pfx, " tick"}, 32'(a_tick), 0);
    chk({pfx, " ls"},   32'(a_ls),  0);
    chk({pfx, " fs"},   32'(a_fs),  0);
  endtask

  // First pixel ticks after a release, default instance
  task automatic chk_first_tick(input string pfx);
    step_to(1);
    chk({pfx, " e1 tick"}, 32'(a_tick), 1);
    chk({pfx, " e1 ppc"},  32'(a_ppc), 799);
    step_to(2);
    chk({pfx, " e2 ppc"},  32'(a_ppc), 0);
    chk({pfx, " e2 plc"},  32'(a_plc), 0);
    chk({pfx, " e2 von"},  32'(a_von), 1);
    chk({pfx, " e2 ls"},   32'(a_ls),  1);
    chk({pfx, " e2 fs"},   32'(a_fs),  1);
    chk({pfx, " e2 tick"}, 32'(a_tick), 0);
    step_to(3);
    chk({pfx, " e3 ls"},   32'(a_ls),  0);
    chk({pfx, " e3 fs"},   32'(a_fs),  0);
    chk({pfx, " e3 ppc"},  32'(a_ppc), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_dflt("rst");
    chk("rst div1 ppc",  32'(b_ppc), 799);
    chk("rst div1 tick", 32'(b_tick), 0);
    chk("rst sm ppc",    32'(c_ppc), 14);
    chk("rst sm plc",    32'(c_plc), 7);
    chk("rst sm hs",     32'(c_hs),  0);
    chk("rst sm vs",     32'(c_vs),  0);

    release_reset();

    // Edge 1..3: first ticks on all three instances
    step_to(1);
    chk("div1 e1 tick", 32'(b_tick), 1);
    chk("div1 e1 ppc",  32'(b_ppc), 799);
    chk("sm e1 tick",   32'(c_tick), 0);
    step_to(2);
    chk("div1 e2 ppc",  32'(b_ppc), 0);
    chk("div1 e2 ls",   32'(b_ls),  1);
    chk("div1 e2 fs",   32'(b_fs),  1);
    chk("sm e2 tick",   32'(c_tick), 1);
    chk("sm e2 ppc",    32'(c_ppc), 14);
    ecnt = 0;
    // re-run the default first-tick checks on the same timeline
    ecnt = 2;
    chk("dflt e2 ppc",  32'(a_ppc), 0);
    chk("dflt e2 fs",   32'(a_fs),  1);
    step_to(3);
    chk("dflt e3 ls",   32'(a_ls),  0);
    chk("dflt e3 tick", 32'(a_tick), 1);
    chk("div1 e3 ppc",  32'(b_ppc), 1);
    chk("div1 e3 ls",   32'(b_ls),  0);
    chk("sm e3 ppc",    32'(c_ppc), 0);
    chk("sm e3 plc",    32'(c_plc), 0);
    chk("sm e3 fs",     32'(c_fs),  1);
    chk("sm e3 tick",   32'(c_tick), 0);
    step_to(4);
    chk("sm e4 fs",     32'(c_fs),  0);
    chk("sm e4 ppc",    32'(c_ppc), 0);

    // Small raster: hsync window columns 10..12, active-high
    step_to(33);
    chk("sm ppc10",     32'(c_ppc), 10);
    chk("sm hs@10",     32'(c_hs),  1);
    step_to(42);
    chk("sm hs@13",     32'(c_hs),  0);

    // Small raster: vsync on lines 5..6 only
    step_to(183);
    chk("sm plc4",      32'(c_plc), 4);
    chk("sm von@l4",    32'(c_von), 0);
    chk("sm vs@l4",     32'(c_vs),  0);
    chk("sm ls@l4",     32'(c_ls),  1);
    step_to(228);
    chk("sm vs@l5",     32'(c_vs),  1);
    step_to(273);
    chk("sm vs@l6",     32'(c_vs),  1);
    step_to(318);
    chk("sm vs@l7",     32'(c_vs),  0);

    // Small raster: frame wraps after exactly 15*8*3 = 360 clocks
    step_to(360);
    chk("sm last ppc",  32'(c_ppc), 14);
    chk("sm last plc",  32'(c_plc), 7);
    chk("sm last fs",   32'(c_fs),  0);
    step_to(363);
    chk("sm wrap ppc",  32'(c_ppc), 0);
    chk("sm wrap plc",  32'(c_plc), 0);
    chk("sm wrap fs",   32'(c_fs),  1);
    step_to(364);
    chk("sm wrap fs2",  32'(c_fs),  0);

    // CLK_DIV=1: line period is 800 clocks
    step_to(801);
    chk("div1 ppc799",  32'(b_ppc), 799);
    chk("div1 plc0",    32'(b_plc), 0);
    step_to(802);
    chk("div1 l1 ppc",  32'(b_ppc), 0);
    chk("div1 l1 plc",  32'(b_plc), 1);
    chk("div1 l1 ls",   32'(b_ls),  1);
    chk("div1 l1 fs",   32'(b_fs),  0);
    chk("div1 l1 tick", 32'(b_tick), 1);

    // Default raster: active edge and hsync window 656..751
    step_to(1280);
    chk("dflt ppc639",  32'(a_ppc), 639);
    chk("dflt von@639", 32'(a_von), 1);
    step_to(1282);
    chk("dflt von@640", 32'(a_von), 0);
    step_to(1312);
    chk("dflt hs@655",  32'(a_hs),  1);
    step_to(1314);
    chk("dflt ppc656",  32'(a_ppc), 656);
    chk("dflt hs@656",  32'(a_hs),  0);
    step_to(1504);
    chk("dflt hs@751",  32'(a_hs),  0);
    step_to(1506);
    chk("dflt hs@752",  32'(a_hs),  1);
    chk("dflt vs l0",   32'(a_vs),  1);
    step_to(1600);
    chk("dflt ppc799",  32'(a_ppc), 799);
    chk("dflt plc0",    32'(a_plc), 0);
    step_to(1602);
    chk("dflt l1 ppc",  32'(a_ppc), 0);
    chk("dflt l1 plc",  32'(a_plc), 1);
    chk("dflt l1 ls",   32'(a_ls),  1);
    chk("dflt l1 fs",   32'(a_fs),  0);
    chk("dflt l1 von",  32'(a_von), 1);
    step_to(1603);
    chk("dflt l1 ls2",  32'(a_ls),  0);

    // Mid-line asynchronous reset, between clock edges
    step_to(2200);
    chk("pre ppc",      32'(a_ppc), 299);
    chk("pre plc",      32'(a_plc), 1);
    chk("pre von",      32'(a_von), 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_dflt("async");
    @(negedge clk);
    release_reset();
    chk_first_tick("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
